// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if
//   Bus bundle between the CPU/DMA requesters, the arbiter and the RAM macro.
//   Parameters: AW = RAM word-address width, DW = data width.
//   Signals:
//     cpu_sel/cpu_we/cpu_addr/cpu_wdata    CPU access request (into arbiter)
//     cpu_rdy/cpu_rvalid                   CPU stall and read-valid (from arbiter)
//     dma_req/dma_we/dma_addr/dma_wdata    DMA access request (into arbiter)
//     dma_gnt/dma_rvalid                   DMA grant and read-valid (from arbiter)
//     ram_we/ram_addr/ram_wdata            RAM macro pins (from arbiter)
//   modport slave  : the arbiter side
//   modport master : the requester / RAM side
interface ram_arbiter_if #(
    parameter int AW = 12,
    parameter int DW = 16
);
    logic          cpu_sel;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_rdy;
    logic          cpu_rvalid;
    logic          dma_req;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic          dma_gnt;
    logic          dma_rvalid;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;

    modport slave (
        input  cpu_sel, cpu_we, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output cpu_rdy, cpu_rvalid, dma_gnt, dma_rvalid,
        output ram_we, ram_addr, ram_wdata
    );

    modport master (
        output cpu_sel, cpu_we, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  cpu_rdy, cpu_rvalid, dma_gnt, dma_rvalid,
        input  ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Shares a single-port registered RAM (1-cycle read latency) between the
//   CPU (default owner) and one DMA master. The DMA steals cycles the CPU
//   does not use; if it has been blocked by the CPU for MAX_WAIT consecutive
//   cycles it is forced ownership and the CPU is stalled through cpu_rdy.
//
//   Ports: clk, reset (synchronous, active high), bus (ram_arbiter_if.slave).
//   Parameters: AW, DW, MAX_WAIT (1..255), BURST_MAX (1..255).
//   Build option: RAM_ARB_BURST_EN
//     defined   - a forced ownership period serves up to BURST_MAX grants
//     undefined - a forced ownership period serves exactly one grant
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   ST_CPU | CPU has priority; DMA only gets cycles with cpu_sel = 0
//   ST_DMA | DMA forced owner; CPU stalled while it selects the RAM
module ram_arbiter #(
    parameter int AW        = 12,
    parameter int DW        = 16,
    parameter int MAX_WAIT  = 8,
    parameter int BURST_MAX = 4
) (
    input logic           clk,
    input logic           reset,
    ram_arbiter_if.slave  bus
);

    localparam logic [0:0] ST_CPU = 1'b0;
    localparam logic [0:0] ST_DMA = 1'b1;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);
`ifdef RAM_ARB_BURST_EN
    localparam logic [7:0] BURST_LAST = 8'(BURST_MAX - 1);
`else
    // burst_cnt is always 0 on the first forced grant, so this ends ST_DMA there.
    localparam logic [7:0] BURST_LAST = 8'd0;
`endif

    if (MAX_WAIT < 1 || MAX_WAIT > 255 || BURST_MAX < 1 || BURST_MAX > 255) begin : g_param_check
        $error("ram_arbiter: MAX_WAIT and BURST_MAX must be within 1..255");
    end

    logic [0:0]    state, state_nxt;
    logic [7:0]    wait_cnt, wait_nxt;
    logic [7:0]    burst_cnt, burst_nxt;
    logic          cpu_own, dma_own;
    logic          cpu_rvalid_q, dma_rvalid_q;
    logic [AW-1:0] addr_sel;
    logic [DW-1:0] wdata_sel;

    always_comb begin
        cpu_own   = 1'b0;
        dma_own   = 1'b0;
        state_nxt = state;
        wait_nxt  = wait_cnt;
        burst_nxt = burst_cnt;
        case (state)
            ST_CPU: begin
                if (bus.cpu_sel) begin
                    cpu_own = 1'b1;
                    if (bus.dma_req) begin
                        wait_nxt = wait_cnt + 8'd1;
                        if (wait_cnt == WAIT_LAST) begin
                            state_nxt = ST_DMA;
                        end
                    end else begin
                        wait_nxt = 8'd0;
                    end
                end else begin
                    // stolen cycle: the CPU is not using the RAM, so no stall
                    dma_own  = bus.dma_req;
                    wait_nxt = 8'd0;
                end
            end
            default: begin
                if (bus.dma_req) begin
                    dma_own = 1'b1;
                    if (burst_cnt == BURST_LAST) begin
                        state_nxt = ST_CPU;
                        wait_nxt  = 8'd0;
                        burst_nxt = 8'd0;
                    end else begin
                        burst_nxt = burst_cnt + 8'd1;
                    end
                end else begin
                    state_nxt = ST_CPU;
                    wait_nxt  = 8'd0;
                    burst_nxt = 8'd0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_CPU;
            wait_cnt     <= 8'd0;
            burst_cnt    <= 8'd0;
            cpu_rvalid_q <= 1'b0;
            dma_rvalid_q <= 1'b0;
        end else begin
            state        <= state_nxt;
            wait_cnt     <= wait_nxt;
            burst_cnt    <= burst_nxt;
            cpu_rvalid_q <= cpu_own & bus.cpu_sel & ~bus.cpu_we;
            dma_rvalid_q <= dma_own & ~bus.dma_we;
        end
    end

    // With no owner the CPU address is presented so the pins stay quiet.
    assign addr_sel  = dma_own ? bus.dma_addr  : bus.cpu_addr;
    assign wdata_sel = dma_own ? bus.dma_wdata : bus.cpu_wdata;

    assign bus.ram_addr   = addr_sel;
    assign bus.ram_wdata  = wdata_sel;
    assign bus.ram_we     = ~reset & (dma_own ? bus.dma_we : (cpu_own & bus.cpu_we));
    assign bus.dma_gnt    = ~reset & dma_own;
    assign bus.cpu_rdy    = reset | (state == ST_CPU) | ~bus.cpu_sel;
    assign bus.cpu_rvalid = cpu_rvalid_q;
    assign bus.dma_rvalid = dma_rvalid_q;

endmodule
